xg_lsu_master: RTL and testbench

Core-side load/store initiator that drives the data-memory interface: the requester end of the data-memory responder.
- Accepts one load/store from the MEM stage at a time.
- Checks alignment, converts sized accesses into word-aligned bus transactions with byte enables, and waits for the memory response.
- Extracts and sign/zero-extends load data and returns a single-cycle response to the pipeline.

---
 rtl/xg_lsu_pkg.sv | 33 +++
 rtl/xg_lsu_lane.sv | 65 ++++++
 rtl/xg_lsu_master.sv | 152 +++++++++++++++
 tb/tb_xg_lsu_master.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xg_lsu_pkg.sv
// xg_lsu_pkg: shared definitions for the load/store initiator.
//   - DM_* access-type codes as seen on req_type
//   - lsu_state_t: FSM state encoding (also exported on dbg_state)
//   - calc_be(): byte enables for an access type at a byte offset
package xg_lsu_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } lsu_state_t;

  // Illegal types return no enables; such requests never reach the bus.
  function automatic logic [3:0] calc_be(input logic [2:0] acc_type,
                                         input logic [1:0] off);
    logic [3:0] be;
    case (acc_type)
      DM_WORD:           be = 4'b1111;
      DM_HALF, DM_HALFU: be = off[1] ? 4'b1100 : 4'b0011;
      DM_BYTE, DM_BYTEU: be = 4'b0001 << off;
      default:           be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/xg_lsu_lane.sv
// xg_lsu_lane: purely combinational byte-lane steering.
// Store path:
//   st_type, st_off, st_wdata -> st_be, st_wdata_lane, st_bad
//   (st_bad = illegal type or misaligned word/half)
// Load path:
//   ld_type, ld_off, ld_raw   -> ld_rdata (sign/zero-extended)
module xg_lsu_lane
  import xg_lsu_pkg::*;
(
  input  logic [2:0]  st_type,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lane,
  output logic        st_bad,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_rdata
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    st_be         = calc_be(st_type, st_off);
    st_wdata_lane = st_wdata;
    st_bad        = 1'b0;
    case (st_type)
      DM_WORD: begin
        st_bad = (st_off != 2'b00);
      end
      DM_HALF, DM_HALFU: begin
        // Replicating the halfword puts it on both lanes; be picks one.
        st_wdata_lane = {2{st_wdata[15:0]}};
        st_bad        = st_off[0];
      end
      DM_BYTE, DM_BYTEU: begin
        st_wdata_lane = {4{st_wdata[7:0]}};
      end
      default: begin
        st_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    half_sel = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_off)
      2'd0:    byte_sel = ld_raw[7:0];
      2'd1:    byte_sel = ld_raw[15:8];
      2'd2:    byte_sel = ld_raw[23:16];
      default: byte_sel = ld_raw[31:24];
    endcase
    case (ld_type)
      DM_WORD:  ld_rdata = ld_raw;
      DM_HALF:  ld_rdata = {{16{half_sel[15]}}, half_sel};
      DM_HALFU: ld_rdata = {16'h0000, half_sel};
      DM_BYTE:  ld_rdata = {{24{byte_sel[7]}}, byte_sel};
      DM_BYTEU: ld_rdata = {24'h000000, byte_sel};
      default:  ld_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/xg_lsu_master.sv
// xg_lsu_master: core-side load/store initiator for the data-memory bus.
// Parameters: TIMEOUT_CYCLES (1..255) cycles allowed in WAIT_RSP,
//             ADDR_W byte-address width.
// Ports:
//   clk, rstn (synchronous, active low)
//   core request : req_valid/req_ready, req_we, req_type, req_addr, req_wdata
//   bus request  : mem_req_valid/mem_req_ready, mem_we, mem_addr, mem_wdata, mem_be
//   bus response : mem_rsp_valid, mem_rsp_rdata
//   core response: rsp_valid (1-cycle pulse), rsp_rdata, rsp_err
//   dbg_state    : current FSM state (lsu_state_t encoding)
// Handshake: a transfer happens on a posedge where valid and ready are both
// high; the initiator holds valid and its payload stable until that edge.
// The bus response channel has no ready: mem_rsp_valid is taken only in
// WAIT_RSP and dropped in every other state.
module xg_lsu_master
  import xg_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);

  // Counter runs 0..TIMEOUT_CYCLES-1; the last value is the final WAIT_RSP cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;

  logic [3:0]  st_be;
  logic [31:0] st_wdata_lane;
  logic        st_bad;
  logic [31:0] ld_rdata;

  assign dbg_state = state;

  // Store side works on the live request; load side on the latched one.
  xg_lsu_lane u_lane (
    .st_type       (req_type),
    .st_off        (req_addr[1:0]),
    .st_wdata      (req_wdata),
    .st_be         (st_be),
    .st_wdata_lane (st_wdata_lane),
    .st_bad        (st_bad),
    .ld_type       (type_q),
    .ld_off        (off_q),
    .ld_raw        (mem_rsp_rdata),
    .ld_rdata      (ld_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 32'h0;
      mem_be        <= 4'h0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'h0;
      rsp_err       <= 1'b0;
      cnt           <= 8'h00;
      we_q          <= 1'b0;
      type_q        <= DM_WORD;
      off_q         <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            type_q    <= req_type;
            off_q     <= req_addr[1:0];
            if (st_bad) begin
              // Rejected locally: the bus never sees this access.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              state     <= ST_RESP;
            end else begin
              mem_req_valid <= 1'b1;
              mem_we        <= req_we;
              mem_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be        <= st_be;
              mem_wdata     <= st_wdata_lane;
              state         <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= 8'h00;
            state         <= ST_WAIT_RSP;
          end
        end

        ST_WAIT_RSP: begin
          // Response is checked first so it wins over a same-cycle timeout.
          if (mem_rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q ? 32'h0 : ld_rdata;
            state     <= ST_RESP;
          end else if (cnt == TO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xg_lsu_master.sv
// tb_xg_lsu_master: directed and randomized checks of xg_lsu_master
// against a byte-arithmetic reference model.
module tb_xg_lsu_master;

  localparam int TO = 4;

  localparam logic [2:0] T_W  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_HU = 3'b010;
  localparam logic [2:0] T_B  = 3'b011;
  localparam logic [2:0] T_BU = 3'b100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          got;
    bit          seen;
    bit          stable;
    bit          one_shot;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } obs_t;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  xg_lsu_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_type      (req_type),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] t);
    case (t)
      T_W:       return 4;
      T_H, T_HU: return 2;
      T_B, T_BU: return 1;
      default:   return 0;
    endcase
  endfunction

  function automatic bit m_bad(input logic [2:0] t, input logic [31:0] addr);
    int sz = m_size(t);
    if (sz == 0) return 1'b1;
    return (addr % sz) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] addr);
    int sz = m_size(t);
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] wd);
    case (m_size(t))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] addr,
                                         input logic [31:0] raw);
    int sz = m_size(t);
    logic [31:0] mask, v;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v = (raw >> (8 * (addr % 4))) & mask;
    if ((t == T_H || t == T_B) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic int m_lat(input logic [2:0] t, input logic [31:0] addr,
                               input int stall, input int delay);
    if (m_bad(t, addr)) return 1;
    return 2 + stall + ((delay < TO) ? delay + 1 : TO);
  endfunction

  // ---------------- driver ----------------
  // Called one time unit after a posedge with the DUT idle; returns in the
  // same phase, one cycle after the response pulse.
  task automatic run_txn(input logic we, input logic [2:0] t, input logic [31:0] addr,
                         input logic [31:0] wd, input int stall, input int delay,
                         input logic [31:0] rd, input bit noise, output obs_t o);
    bit hs, hs_next;
    int widx;
    o.got = 0; o.seen = 0; o.stable = 1; o.one_shot = 0; o.lat = -1;
    o.rdata = 'x; o.err = 'x; o.addr = 'x; o.wdata = 'x; o.be = 'x; o.we = 'x;
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_type = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    hs = 0; widx = 0;
    for (int k = 1; k <= 60; k++) begin
      if (rsp_valid) begin
        o.got = 1; o.lat = k; o.rdata = rsp_rdata; o.err = rsp_err;
        break;
      end
      hs_next = hs;
      if (!hs) begin
        if (mem_req_valid) begin
          if (!o.seen) begin
            o.seen = 1; o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
          end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o.addr, o.be, o.wdata, o.we}) begin
            o.stable = 0;
          end
          mem_req_ready = (k > stall);
          hs_next = (k > stall);
        end else if (o.seen) begin
          o.stable = 0;
        end
        mem_rsp_valid = noise ? 1'($urandom) : 1'b0;
        mem_rsp_rdata = $urandom;
      end else begin
        mem_rsp_valid = (widx == delay);
        mem_rsp_rdata = (widx == delay) ? rd : $urandom;
        widx++;
      end
      @(posedge clk); #1;
      hs = hs_next; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    end
    @(posedge clk); #1;
    o.one_shot = !rsp_valid && req_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be, rsp_valid, rsp_rdata, rsp_err, dbg_state}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset_values got rdy=%b mrv=%b we=%b a=%h wd=%h be=%b rv=%b rd=%h err=%b st=%0d exp rdy=1 rest 0",
               req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be, rsp_valid, rsp_rdata, rsp_err, dbg_state);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    obs_t o;
    run_txn(1'b1, T_W, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h1234_5678, 0, o);
    total++;
    if ({o.seen, o.addr, o.be, o.wdata, o.we} !== {1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b1}) begin
      bad++;
      $display("FAIL sw_bus got seen=%b a=%h be=%b wd=%h we=%b exp a=00000010 be=1111 wd=deadbeef we=1",
               o.seen, o.addr, o.be, o.wdata, o.we);
    end
    total++;
    if ({o.lat, o.rdata, o.err, o.one_shot} !== {32'd3, 32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL sw_rsp got lat=%0d rd=%h err=%b oneshot=%b exp lat=3 rd=0 err=0 oneshot=1",
               o.lat, o.rdata, o.err, o.one_shot);
    end
  endtask

  task automatic test_byte_lanes();
    obs_t o;
    run_txn(1'b1, T_B, 32'h13, 32'h0000_00A5, 0, 0, 32'hFFFF_FFFF, 0, o);
    total++;
    if ({o.be, o.wdata, o.addr, o.rdata, o.err} !== {4'b1000, 32'hA5A5_A5A5, 32'h10, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL sb_lane got be=%b wd=%h a=%h rd=%h err=%b exp be=1000 wd=a5a5a5a5 a=10 rd=0 err=0",
               o.be, o.wdata, o.addr, o.rdata, o.err);
    end
    run_txn(1'b0, T_B, 32'h13, 32'h0, 0, 0, 32'h80FF_7F01, 0, o);
    total++;
    if ({o.be, o.we, o.rdata, o.err, o.lat} !== {4'b1000, 1'b0, 32'hFFFF_FF80, 1'b0, 32'd3}) begin
      bad++;
      $display("FAIL lb_sext got be=%b we=%b rd=%h err=%b lat=%0d exp be=1000 we=0 rd=ffffff80 err=0 lat=3",
               o.be, o.we, o.rdata, o.err, o.lat);
    end
    run_txn(1'b0, T_BU, 32'h13, 32'h0, 0, 1, 32'h80FF_7F01, 0, o);
    total++;
    if ({o.rdata, o.err} !== {32'h0000_0080, 1'b0}) begin
      bad++;
      $display("FAIL lbu_zext got rd=%h err=%b exp rd=00000080 err=0", o.rdata, o.err);
    end
  endtask

  task automatic test_half_lanes();
    obs_t o;
    run_txn(1'b0, T_H, 32'h22, 32'h0, 0, 0, 32'h8001_FFFF, 0, o);
    total++;
    if ({o.be, o.addr, o.rdata, o.err} !== {4'b1100, 32'h20, 32'hFFFF_8001, 1'b0}) begin
      bad++;
      $display("FAIL lh_sext got be=%b a=%h rd=%h err=%b exp be=1100 a=20 rd=ffff8001 err=0",
               o.be, o.addr, o.rdata, o.err);
    end
    run_txn(1'b0, T_HU, 32'h22, 32'h0, 0, 0, 32'h8001_FFFF, 0, o);
    total++;
    if ({o.rdata, o.err} !== {32'h0000_8001, 1'b0}) begin
      bad++;
      $display("FAIL lhu_zext got rd=%h err=%b exp rd=00008001 err=0", o.rdata, o.err);
    end
    run_txn(1'b1, T_H, 32'h44, 32'hFFFF_BEEF, 0, 0, 32'h0, 0, o);
    total++;
    if ({o.be, o.wdata} !== {4'b0011, 32'hBEEF_BEEF}) begin
      bad++;
      $display("FAIL sh_lane got be=%b wd=%h exp be=0011 wd=beefbeef", o.be, o.wdata);
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic [2:0] tt[3] = '{T_W, 3'b111, T_H};
    logic [31:0] aa[3] = '{32'h21, 32'h40, 32'h23};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, tt[i], aa[i], 32'h0, 0, 0, 32'hFFFF_FFFF, 0, o);
      total++;
      if ({o.seen, o.lat, o.err, o.rdata, o.one_shot} !== {1'b0, 32'd1, 1'b1, 32'h0, 1'b1}) begin
        bad++;
        $display("FAIL err_case%0d got busreq=%b lat=%0d err=%b rd=%h oneshot=%b exp busreq=0 lat=1 err=1 rd=0 oneshot=1",
                 i, o.seen, o.lat, o.err, o.rdata, o.one_shot);
      end
    end
  endtask

  task automatic test_stall_timeout();
    obs_t o;
    run_txn(1'b1, T_W, 32'h100, 32'h1234_5678, 5, 10, 32'h0, 1, o);
    total++;
    if ({o.stable, o.addr, o.be, o.wdata} !== {1'b1, 32'h100, 4'b1111, 32'h1234_5678}) begin
      bad++;
      $display("FAIL stall_hold got stable=%b a=%h be=%b wd=%h exp stable=1 a=100 be=1111 wd=12345678",
               o.stable, o.addr, o.be, o.wdata);
    end
    total++;
    if ({o.lat, o.err, o.rdata} !== {32'd11, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL timeout got lat=%0d err=%b rd=%h exp lat=11 err=1 rd=0", o.lat, o.err, o.rdata);
    end
    // Response arriving in the last allowed cycle beats the timeout.
    run_txn(1'b0, T_W, 32'h30, 32'h0, 0, TO - 1, 32'hCAFE_F00D, 0, o);
    total++;
    if ({o.lat, o.err, o.rdata} !== {32'd6, 1'b0, 32'hCAFE_F00D}) begin
      bad++;
      $display("FAIL rsp_wins got lat=%0d err=%b rd=%h exp lat=6 err=0 rd=cafef00d", o.lat, o.err, o.rdata);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int stray_rsp = 0;
    req_valid = 1'b1; req_we = 1'b0; req_type = T_W; req_addr = 32'h50;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    total++;
    if ({req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be, rsp_valid, rsp_rdata, rsp_err}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_values got rdy=%b mrv=%b we=%b a=%h wd=%h be=%b rv=%b rd=%h err=%b exp rdy=1 rest 0",
               req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be, rsp_valid, rsp_rdata, rsp_err);
    end
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid || mem_req_valid || !req_ready) stray_rsp++;
      @(posedge clk); #1;
    end
    total++;
    if (stray_rsp !== 0) begin
      bad++;
      $display("FAIL stray_rsp got disturbed_cycles=%0d exp 0", stray_rsp);
    end
    run_txn(1'b0, T_BU, 32'h52, 32'h0, 1, 0, 32'h00C3_0000, 0, o);
    total++;
    if ({o.rdata, o.err, o.lat, o.be} !== {32'h0000_00C3, 1'b0, 32'd4, 4'b0100}) begin
      bad++;
      $display("FAIL after_reset got rd=%h err=%b lat=%0d be=%b exp rd=000000c3 err=0 lat=4 be=0100",
               o.rdata, o.err, o.lat, o.be);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic we;
    logic [2:0] t;
    logic [31:0] addr, wd, rd, exp_rd;
    int stall, delay, exp_lat;
    bit exp_err, inval;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom);
      t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      addr = $urandom; wd = $urandom; rd = $urandom;
      stall = $urandom_range(0, 3);
      delay = $urandom_range(0, 5);
      inval = m_bad(t, addr);
      exp_err = inval || (delay >= TO);
      exp_q.push_back((we || exp_err) ? 32'h0 : m_load(t, addr, rd));
      exp_lat = m_lat(t, addr, stall, delay);
      run_txn(we, t, addr, wd, stall, delay, rd, 1, o);
      exp_rd = exp_q.pop_front();
      total++;
      if ({o.rdata, o.err, o.lat, o.one_shot} !== {exp_rd, exp_err, exp_lat, 1'b1}) begin
        bad++;
        $display("FAIL rand%0d_rsp we=%b t=%0d a=%h got rd=%h err=%b lat=%0d oneshot=%b exp rd=%h err=%b lat=%0d oneshot=1",
                 n, we, t, addr, o.rdata, o.err, o.lat, o.one_shot, exp_rd, exp_err, exp_lat);
      end
      total++;
      if (inval) begin
        if (o.seen !== 1'b0) begin
          bad++;
          $display("FAIL rand%0d_nobus got busreq=%b exp 0", n, o.seen);
        end
      end else if ({o.seen, o.stable, o.we, o.addr, o.be, o.wdata}
                   !== {1'b1, 1'b1, we, addr & 32'hFFFF_FFFC, m_be(t, addr),
                        we ? m_wdata(t, wd) : o.wdata}) begin
        bad++;
        $display("FAIL rand%0d_bus t=%0d got seen=%b stable=%b we=%b a=%h be=%b wd=%h exp we=%b a=%h be=%b wd=%h",
                 n, t, o.seen, o.stable, o.we, o.addr, o.be, o.wdata,
                 we, addr & 32'hFFFF_FFFC, m_be(t, addr), m_wdata(t, wd));
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte_lanes();
    test_half_lanes();
    test_errors();
    test_stall_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
